// File: rtl/clk_gen_bank.sv
`default_nettype none
// ============================================================================
// Module      : clk_gen_bank
// Description : Multi-channel programmable test-clock generator with per-channel
//               high/low rates, start polarity, phase offset and edge strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_gen_bank #(
    parameter int CHANNELS   = 4,
    parameter int RATE_WIDTH = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           clk_en_i,
    input  logic [CHANNELS-1:0]            start_i,
    input  logic [CHANNELS-1:0]            stop_i,
    input  logic [CHANNELS-1:0]            cfg_update_i,
    input  logic [CHANNELS-1:0]            polarity_i,
    input  logic [CHANNELS*RATE_WIDTH-1:0] high_rate_i,
    input  logic [CHANNELS*RATE_WIDTH-1:0] low_rate_i,
    input  logic [CHANNELS*RATE_WIDTH-1:0] phase_i,
    output logic [CHANNELS-1:0]            clk_o,
    output logic [CHANNELS-1:0]            rise_o,
    output logic [CHANNELS-1:0]            fall_o,
    output logic [CHANNELS-1:0]            busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PHASE = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [RATE_WIDTH-1:0] c_one = {{(RATE_WIDTH-1){1'b0}}, 1'b1};

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        state_t                r_state;
        logic [RATE_WIDTH-1:0] r_cnt;
        logic [RATE_WIDTH-1:0] r_high;
        logic [RATE_WIDTH-1:0] r_low;
        logic [RATE_WIDTH-1:0] r_phase;
        logic [RATE_WIDTH-1:0] r_stage_high;
        logic [RATE_WIDTH-1:0] r_stage_low;
        logic                  r_pol;
        logic                  r_clk;
        logic                  r_rise;
        logic                  r_fall;
        logic                  r_busy;
        logic                  r_upd_pend;
        logic                  r_stop_pend;

        logic [RATE_WIDTH-1:0] w_eff_high;
        logic [RATE_WIDTH-1:0] w_eff_low;
        logic [RATE_WIDTH-1:0] w_rate;
        logic [RATE_WIDTH-1:0] w_start_phase;
        logic                  w_cnt_done;
        logic                  w_phase_done;
        logic                  w_boundary;

        // A programmed rate of zero behaves as a one-cycle phase.
        assign w_eff_high    = (r_high == '0) ? c_one : r_high;
        assign w_eff_low     = (r_low  == '0) ? c_one : r_low;
        assign w_rate        = r_clk ? w_eff_high : w_eff_low;
        assign w_start_phase = phase_i[g*RATE_WIDTH +: RATE_WIDTH];
        assign w_cnt_done    = (r_cnt == (w_rate - c_one));
        assign w_phase_done  = (r_cnt == (r_phase - c_one));
        // The toggle about to happen returns the output to its idle level.
        assign w_boundary    = ((!r_clk) == r_pol);

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                r_state      <= ST_IDLE;
                r_cnt        <= '0;
                r_high       <= '0;
                r_low        <= '0;
                r_phase      <= '0;
                r_stage_high <= '0;
                r_stage_low  <= '0;
                r_pol        <= 1'b0;
                r_clk        <= 1'b0;
                r_rise       <= 1'b0;
                r_fall       <= 1'b0;
                r_busy       <= 1'b0;
                r_upd_pend   <= 1'b0;
                r_stop_pend  <= 1'b0;
            end else if (!clk_en_i) begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end else begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;
                case (r_state)
                    ST_IDLE: begin
                        if (start_i[g] && !stop_i[g]) begin
                            r_pol       <= polarity_i[g];
                            r_clk       <= polarity_i[g];
                            r_high      <= high_rate_i[g*RATE_WIDTH +: RATE_WIDTH];
                            r_low       <= low_rate_i[g*RATE_WIDTH +: RATE_WIDTH];
                            r_phase     <= w_start_phase;
                            r_cnt       <= '0;
                            r_busy      <= 1'b1;
                            r_upd_pend  <= 1'b0;
                            r_stop_pend <= 1'b0;
                            r_state     <= (w_start_phase != '0) ? ST_PHASE : ST_RUN;
                        end
                    end
                    ST_PHASE: begin
                        if (stop_i[g]) begin
                            r_state     <= ST_IDLE;
                            r_busy      <= 1'b0;
                            r_cnt       <= '0;
                            r_upd_pend  <= 1'b0;
                            r_stop_pend <= 1'b0;
                        end else begin
                            if (cfg_update_i[g]) begin
                                r_stage_high <= high_rate_i[g*RATE_WIDTH +: RATE_WIDTH];
                                r_stage_low  <= low_rate_i[g*RATE_WIDTH +: RATE_WIDTH];
                                r_upd_pend   <= 1'b1;
                            end
                            if (w_phase_done) begin
                                r_state <= ST_RUN;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + c_one;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (stop_i[g]) begin
                            r_stop_pend <= 1'b1;
                        end
                        if (cfg_update_i[g]) begin
                            r_stage_high <= high_rate_i[g*RATE_WIDTH +: RATE_WIDTH];
                            r_stage_low  <= low_rate_i[g*RATE_WIDTH +: RATE_WIDTH];
                            r_upd_pend   <= 1'b1;
                        end
                        if (w_cnt_done) begin
                            r_clk  <= !r_clk;
                            r_cnt  <= '0;
                            r_rise <= !r_clk;
                            r_fall <= r_clk;
                            if (w_boundary) begin
                                // Only a request from an earlier cycle is applied here.
                                if (r_upd_pend) begin
                                    r_high <= r_stage_high;
                                    r_low  <= r_stage_low;
                                    if (!cfg_update_i[g]) begin
                                        r_upd_pend <= 1'b0;
                                    end
                                end
                                if (r_stop_pend) begin
                                    r_state     <= ST_IDLE;
                                    r_busy      <= 1'b0;
                                    r_stop_pend <= 1'b0;
                                    r_upd_pend  <= 1'b0;
                                end
                            end
                        end else begin
                            r_cnt <= r_cnt + c_one;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end

        assign clk_o[g]  = r_clk;
        assign rise_o[g] = r_rise;
        assign fall_o[g] = r_fall;
        assign busy_o[g] = r_busy;
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_gen_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_gen_bank
// Description : Directed self-checking bench for clk_gen_bank.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_gen_bank;

    localparam int CH = 4;
    localparam int RW = 16;

    logic             clk_i = 1'b0;
    logic             rst_n_i;
    logic             clk_en_i;
    logic [CH-1:0]    start_i;
    logic [CH-1:0]    stop_i;
    logic [CH-1:0]    cfg_update_i;
    logic [CH-1:0]    polarity_i;
    logic [CH*RW-1:0] high_rate_i;
    logic [CH*RW-1:0] low_rate_i;
    logic [CH*RW-1:0] phase_i;
    logic [CH-1:0]    clk_o;
    logic [CH-1:0]    rise_o;
    logic [CH-1:0]    fall_o;
    logic [CH-1:0]    busy_o;

    int errors = 0;
    int checks = 0;

    clk_gen_bank #(.CHANNELS(CH), .RATE_WIDTH(RW)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .clk_en_i    (clk_en_i),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .cfg_update_i(cfg_update_i),
        .polarity_i  (polarity_i),
        .high_rate_i (high_rate_i),
        .low_rate_i  (low_rate_i),
        .phase_i     (phase_i),
        .clk_o       (clk_o),
        .rise_o      (rise_o),
        .fall_o      (fall_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        rst_n_i      = 1'b0;
        clk_en_i     = 1'b1;
        start_i      = '0;
        stop_i       = '0;
        cfg_update_i = '0;
        polarity_i   = '0;
        high_rate_i  = '0;
        low_rate_i   = '0;
        phase_i      = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        tick();
    endtask

    task automatic set_cfg(input int c, input bit pol, input int hi, input int lo, input int ph);
        polarity_i[c]           = pol;
        high_rate_i[c*RW +: RW] = RW'(hi);
        low_rate_i[c*RW +: RW]  = RW'(lo);
        phase_i[c*RW +: RW]     = RW'(ph);
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        #3;
        checks++;
        if ({clk_o, rise_o, fall_o, busy_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", {clk_o, rise_o, fall_o, busy_o});
        end
        apply_reset();
    endtask

    task automatic test_basic();
        logic [3:0] exp;
        int m;
        apply_reset();
        set_cfg(0, 1'b1, 2, 3, 0);
        start_i[0] = 1'b1;
        tick();
        start_i[0] = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) tick();
            m = k % 5;
            exp = {m < 2, (k > 0) && (m == 0), m == 2, 1'b1};
            checks++;
            if ({clk_o[0], rise_o[0], fall_o[0], busy_o[0]} !== exp) begin
                errors++;
                $display("FAIL basic k=%0d: got clk/rise/fall/busy=%b required %b", k,
                         {clk_o[0], rise_o[0], fall_o[0], busy_o[0]}, exp);
            end
        end
    endtask

    task automatic test_phase_offset();
        logic [7:0] exp;
        logic       l0, l1, r1, f1;
        apply_reset();
        set_cfg(0, 1'b0, 2, 2, 0);
        set_cfg(1, 1'b0, 2, 2, 4);
        start_i[1:0] = 2'b11;
        tick();
        start_i[1:0] = 2'b00;
        for (int k = 0; k < 48; k++) begin
            if (k > 0) tick();
            l0 = ((k / 2) % 2) == 1;
            l1 = (k >= 4) && ((((k - 4) / 2) % 2) == 1);
            r1 = (k >= 6) && (((k - 4) % 4) == 2);
            f1 = (k >= 8) && (((k - 4) % 4) == 0);
            exp = {l1, r1, f1, 1'b1, l0, (k % 4) == 2, (k > 0) && ((k % 4) == 0), 1'b1};
            checks++;
            if ({clk_o[1], rise_o[1], fall_o[1], busy_o[1],
                 clk_o[0], rise_o[0], fall_o[0], busy_o[0]} !== exp) begin
                errors++;
                $display("FAIL phase_offset k=%0d: got ch1,ch0=%b required %b", k,
                         {clk_o[1], rise_o[1], fall_o[1], busy_o[1],
                          clk_o[0], rise_o[0], fall_o[0], busy_o[0]}, exp);
            end
        end
    endtask

    task automatic test_cfg_update();
        logic [3:0] exp;
        logic       lvl, r, f;
        apply_reset();
        set_cfg(2, 1'b0, 4, 4, 0);
        start_i[2] = 1'b1;
        tick();
        start_i[2] = 1'b0;
        for (int k = 0; k < 18; k++) begin
            if (k > 0) tick();
            if (k < 4)      lvl = 1'b0;
            else if (k < 8) lvl = 1'b1;
            else            lvl = ((k - 8) % 2) == 1;
            r = (k == 4) || ((k >= 8) && (((k - 8) % 2) == 1));
            f = (k >= 8) && (((k - 8) % 2) == 0);
            exp = {lvl, r, f, 1'b1};
            checks++;
            if ({clk_o[2], rise_o[2], fall_o[2], busy_o[2]} !== exp) begin
                errors++;
                $display("FAIL cfg_update k=%0d: got clk/rise/fall/busy=%b required %b", k,
                         {clk_o[2], rise_o[2], fall_o[2], busy_o[2]}, exp);
            end
            if (k == 5) begin
                cfg_update_i[2] = 1'b1;
                high_rate_i[2*RW +: RW] = RW'(1);
                low_rate_i[2*RW +: RW]  = RW'(1);
            end else begin
                cfg_update_i[2] = 1'b0;
            end
        end
    endtask

    task automatic test_stop();
        logic [3:0] exp;
        apply_reset();
        set_cfg(3, 1'b0, 3, 3, 0);
        start_i[3] = 1'b1;
        tick();
        start_i[3] = 1'b0;
        for (int k = 0; k < 14; k++) begin
            if (k > 0) tick();
            exp = {(k >= 3) && (k <= 5), k == 3, k == 6, k < 6};
            checks++;
            if ({clk_o[3], rise_o[3], fall_o[3], busy_o[3]} !== exp) begin
                errors++;
                $display("FAIL stop k=%0d: got clk/rise/fall/busy=%b required %b", k,
                         {clk_o[3], rise_o[3], fall_o[3], busy_o[3]}, exp);
            end
            stop_i[3] = (k == 4);
        end
    endtask

    task automatic test_zero_rate_clk_en();
        logic [3:0] exp;
        int j;
        apply_reset();
        set_cfg(0, 1'b0, 0, 0, 0);
        start_i[0] = 1'b1;
        tick();
        start_i[0] = 1'b0;
        for (int k = 0; k < 13; k++) begin
            if (k > 0) tick();
            if (k >= 5 && k <= 7) begin
                exp = 4'b0001;
            end else begin
                j = (k <= 4) ? k : k - 3;
                exp = {(j % 2) == 1, (j % 2) == 1, (j > 0) && ((j % 2) == 0), 1'b1};
            end
            checks++;
            if ({clk_o[0], rise_o[0], fall_o[0], busy_o[0]} !== exp) begin
                errors++;
                $display("FAIL zero_rate_clk_en k=%0d: got clk/rise/fall/busy=%b required %b", k,
                         {clk_o[0], rise_o[0], fall_o[0], busy_o[0]}, exp);
            end
            if (k == 4) clk_en_i = 1'b0;
            if (k == 7) clk_en_i = 1'b1;
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] exp;
        apply_reset();
        set_cfg(0, 1'b0, 5, 5, 0);
        start_i[0] = 1'b1;
        tick();
        start_i[0] = 1'b0;
        repeat (7) tick();
        checks++;
        if (clk_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_high: got clk=%b required 1", clk_o[0]);
        end
        #2;
        rst_n_i = 1'b0;
        #1;
        checks++;
        if ({clk_o, rise_o, fall_o, busy_o} !== '0) begin
            errors++;
            $display("FAIL async_reset: got %h required 0", {clk_o, rise_o, fall_o, busy_o});
        end
        tick();
        #2;
        rst_n_i = 1'b1;
        tick();
        set_cfg(0, 1'b1, 2, 2, 1);
        start_i[0] = 1'b1;
        tick();
        start_i[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) tick();
            exp = {(k < 3) || ((((k - 3) / 2) % 2) == 1),
                   (k >= 3) && (((k - 3) % 4) == 2),
                   (k >= 3) && (((k - 3) % 4) == 0), 1'b1};
            checks++;
            if ({clk_o[0], rise_o[0], fall_o[0], busy_o[0]} !== exp) begin
                errors++;
                $display("FAIL post_reset_start k=%0d: got clk/rise/fall/busy=%b required %b", k,
                         {clk_o[0], rise_o[0], fall_o[0], busy_o[0]}, exp);
            end
        end
    endtask

    task automatic test_start_stop_idle();
        apply_reset();
        set_cfg(1, 1'b1, 2, 2, 0);
        start_i[1] = 1'b1;
        stop_i[1]  = 1'b1;
        tick();
        start_i[1] = 1'b0;
        stop_i[1]  = 1'b0;
        tick();
        checks++;
        if ({clk_o[1], busy_o[1]} !== 2'b00) begin
            errors++;
            $display("FAIL start_stop_idle: got clk/busy=%b required 00", {clk_o[1], busy_o[1]});
        end
    endtask

    initial begin
        rst_n_i      = 1'b1;
        clk_en_i     = 1'b1;
        start_i      = '0;
        stop_i       = '0;
        cfg_update_i = '0;
        polarity_i   = '0;
        high_rate_i  = '0;
        low_rate_i   = '0;
        phase_i      = '0;
        test_reset();
        test_basic();
        test_phase_offset();
        test_cfg_update();
        test_stop();
        test_zero_rate_clk_en();
        test_async_reset();
        test_start_stop_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
